// File: rtl/led_arb_pkg.sv
// Shared encodings and constants for the LED blink arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  // Heartbeat period in prescaler ticks (one LED toggle per period).
  localparam int unsigned HB_TICKS = 4;

endpackage

// File: rtl/led_tick_prescaler.sv
// Divides clk into one-cycle ticks every TICK_DIV cycles; clear forces the count back to 0.
module led_tick_prescaler #(
  parameter int unsigned TICK_DIV = 1500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_r;

  // Phase counter: 0..TICK_DIV-1, wrapping on the tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + PW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = enable && !clear && (cnt_r == CNT_LAST);

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin owner of the board LED; each grant plays N blinks then a dark gap.
// Optional idle heartbeat when LED_ARB_HEARTBEAT_EN is defined.
module led_blink_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned TICK_DIV  = 1500000,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*CNT_W-1:0]   req_count,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       led_out
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

  arb_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [GW-1:0]    gap_r;
  logic [OW-1:0]    last_r;
  logic [OW:0]      pick_s;
  logic [CNT_W-1:0] sel_cnt_s;
  logic             pick_found_s;
  logic [OW-1:0]    pick_idx_s;
  logic             tick_s;
  logic             presc_clear_s;

`ifdef LED_ARB_HEARTBEAT_EN
  localparam int unsigned HB_W = $clog2(HB_TICKS);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_TICKS - 1);
  logic [HB_W-1:0] hb_r;
`endif

  // First set bit searching upward from last+1 with wrap; returns {found, index}.
  function automatic logic [OW:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [OW-1:0] last);
    logic [OW:0]   res;
    logic [OW-1:0] idx;
    res = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      idx = OW'((int'(last) + i) % int'(NUM_REQ));
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Arbitration pick and the winner's blink count.
  always_comb begin
    pick_s    = rr_pick(req, last_r);
    sel_cnt_s = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (OW'(i) == pick_s[OW-1:0]) begin
        sel_cnt_s = req_count[i*CNT_W +: CNT_W];
      end else begin
        sel_cnt_s = sel_cnt_s;
      end
    end
  end

  assign pick_found_s = pick_s[OW];
  assign pick_idx_s   = pick_s[OW-1:0];

`ifdef LED_ARB_HEARTBEAT_EN
  assign presc_clear_s = (state_r == ST_IDLE) && pick_found_s;
`else
  assign presc_clear_s = (state_r == ST_IDLE);
`endif

  led_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (presc_clear_s),
    .enable  (1'b1),
    .tick    (tick_s)
  );

  // Burst sequencer with registered grant/done/busy/owner/led outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      owner   <= '0;
      led_out <= 1'b0;
      cnt_r   <= '0;
      gap_r   <= '0;
      last_r  <= OW'(NUM_REQ - 1);
`ifdef LED_ARB_HEARTBEAT_EN
      hb_r    <= '0;
`endif
    end else begin
      grant <= '0;
      done  <= '0;
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            grant  <= onehot(pick_idx_s);
            busy   <= 1'b1;
            owner  <= pick_idx_s;
            last_r <= pick_idx_s;
            cnt_r  <= sel_cnt_s;
            gap_r  <= '0;
`ifdef LED_ARB_HEARTBEAT_EN
            hb_r   <= '0;
`endif
            if (sel_cnt_s != '0) begin
              state_r <= ST_ON;
              led_out <= 1'b1;
            end else begin
              state_r <= ST_GAP;
              led_out <= 1'b0;
            end
          end else begin
`ifdef LED_ARB_HEARTBEAT_EN
            if (tick_s) begin
              if (hb_r == HB_LAST) begin
                hb_r    <= '0;
                led_out <= ~led_out;
              end else begin
                hb_r <= hb_r + HB_W'(1);
              end
            end
`else
            led_out <= 1'b0;
`endif
          end
        end
        ST_ON: begin
          if (tick_s) begin
            state_r <= ST_OFF;
            led_out <= 1'b0;
          end
        end
        ST_OFF: begin
          // OFF is only reached with a nonzero count, so the decrement never wraps.
          if (tick_s) begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
              state_r <= ST_GAP;
            end else begin
              state_r <= ST_ON;
              led_out <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (tick_s) begin
            if (gap_r == GAP_LAST) begin
              state_r <= ST_IDLE;
              done    <= onehot(owner);
              busy    <= 1'b0;
              gap_r   <= '0;
            end else begin
              gap_r <= gap_r + GW'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          led_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
